// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute-side signals of the hazard and stall controller.
// The master drives the pipeline inputs; the slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [XLEN-1:0]   id_inst;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              ex_load_en;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_mc_start;
  logic              branch_taken;
  logic              stall_f;
  logic              stall_d;
  logic              bubble_d;
  logic              bubble_e;
  logic              flush_fd;
  logic [XLEN-1:0]   inst_out;
  logic [XLEN-1:0]   pc_out;
  logic              busy;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_inst, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_load_en, ex_rd_addr, ex_mc_start, branch_taken,
    input  stall_f, stall_d, bubble_d, bubble_e, flush_fd,
    input  inst_out, pc_out, busy, stall_count
  );

  modport slave (
    input  id_inst, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_load_en, ex_rd_addr, ex_mc_start, branch_taken,
    output stall_f, stall_d, bubble_d, bubble_e, flush_fd,
    output inst_out, pc_out, busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle-EX stall controller with branch flush, decode replay
// and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter int              LOAD_LAT = 1,
  parameter int              MC_LAT   = 4,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input logic              clk,
  input logic              reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
  localparam int LW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [LW-1:0] LD_INIT = LW'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
  localparam logic [LW-1:0] MC_INIT = LW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } state_e;

  state_e           state_q;
  logic [LW-1:0]    cnt_q;
  logic [XLEN-1:0]  hold_inst_q;
  logic [XLEN-1:0]  hold_pc_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             hz_s;
  logic             stall_f_s;
  logic             stall_d_s;
  logic             bubble_d_s;
  logic             bubble_e_s;
  logic             flush_fd_s;
  logic             busy_s;
  logic [XLEN-1:0]  inst_s;
  logic [XLEN-1:0]  pc_s;
  logic [CNT_W-1:0] count_s;

  // Stall/flush decode from current state and decode/execute inputs
  always_comb begin
    hz_s = bus.ex_load_en && (bus.ex_rd_addr != '0) &&
           ((bus.id_rs1_used && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
            (bus.id_rs2_used && (bus.id_rs2_addr == bus.ex_rd_addr)));
    stall_f_s  = 1'b0;
    stall_d_s  = 1'b0;
    bubble_d_s = 1'b0;
    bubble_e_s = 1'b0;
    flush_fd_s = 1'b0;
    busy_s     = 1'b0;
    inst_s     = bus.id_inst;
    pc_s       = bus.id_pc;
    count_s    = stall_cnt_q;
    if (reset) begin
      count_s = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // In IDLE the instruction being captured is the one on id_inst
          if (bus.branch_taken) begin
            flush_fd_s = 1'b1;
            bubble_d_s = 1'b1;
          end else if (bus.ex_mc_start) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            bubble_e_s = 1'b1;
          end else if (hz_s) begin
            stall_f_s  = 1'b1;
            bubble_d_s = 1'b1;
          end else begin
            stall_f_s  = 1'b0;
          end
        end
        LD_STALL: begin
          busy_s = 1'b1;
          inst_s = hold_inst_q;
          pc_s   = hold_pc_q;
          if (bus.branch_taken) begin
            flush_fd_s = 1'b1;
            bubble_d_s = 1'b1;
          end else begin
            stall_f_s  = 1'b1;
            bubble_d_s = 1'b1;
          end
        end
        MC_BUSY: begin
          busy_s     = 1'b1;
          inst_s     = hold_inst_q;
          pc_s       = hold_pc_q;
          stall_f_s  = 1'b1;
          stall_d_s  = 1'b1;
          bubble_e_s = 1'b1;
        end
        default: begin
          busy_s = 1'b0;
        end
      endcase
    end
  end

  // FSM, replay hold registers and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall_f_s && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.branch_taken) begin
            state_q <= IDLE;
          end else if (bus.ex_mc_start) begin
            hold_inst_q <= bus.id_inst;
            hold_pc_q   <= bus.id_pc;
            if (MC_LAT > 1) begin
              state_q <= MC_BUSY;
              cnt_q   <= MC_INIT;
            end
          end else if (hz_s) begin
            hold_inst_q <= bus.id_inst;
            hold_pc_q   <= bus.id_pc;
            if (LOAD_LAT > 1) begin
              state_q <= LD_STALL;
              cnt_q   <= LD_INIT;
            end
          end
        end
        LD_STALL: begin
          if (bus.branch_taken || (cnt_q == '0)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - LW'(1);
          end
        end
        MC_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - LW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_f     = stall_f_s;
  assign bus.stall_d     = stall_d_s;
  assign bus.bubble_d    = bubble_d_s;
  assign bus.bubble_e    = bubble_e_s;
  assign bus.flush_fd    = flush_fd_s;
  assign bus.busy        = busy_s;
  assign bus.inst_out    = inst_s;
  assign bus.pc_out      = pc_s;
  assign bus.stall_count = count_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two configurations driven by identical stimulus,
// a directed vector table, hand-written multi-cycle sequences and random traffic.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic        rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        ld;
    logic [4:0]  rd;
    logic        mc;
    logic        br;
  } stim_t;

  typedef struct packed {
    logic        sf;
    logic        sd;
    logic        bd;
    logic        be;
    logic        ff;
    logic        busy;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  // Remaining stall cycles after the current one plus what was held
  typedef struct {
    int          rem;
    bit          mc;
    logic [31:0] hi;
    logic [31:0] hp;
    int          cnt;
  } mstate_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic    clk;
  stim_t   cur;
  int      checks;
  int      failures;
  mstate_t m_a;
  mstate_t m_b;
  exp_t    obs_a;
  exp_t    obs_b;
  vec_t    tbl [13];

  hazard_stall_ctrl_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) ifa ();
  hazard_stall_ctrl_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  ifb ();

  assign ifa.id_inst      = cur.inst;
  assign ifa.id_pc        = cur.pc;
  assign ifa.id_rs1_addr  = cur.rs1;
  assign ifa.id_rs2_addr  = cur.rs2;
  assign ifa.id_rs1_used  = cur.u1;
  assign ifa.id_rs2_used  = cur.u2;
  assign ifa.ex_load_en   = cur.ld;
  assign ifa.ex_rd_addr   = cur.rd;
  assign ifa.ex_mc_start  = cur.mc;
  assign ifa.branch_taken = cur.br;
  assign ifb.id_inst      = cur.inst;
  assign ifb.id_pc        = cur.pc;
  assign ifb.id_rs1_addr  = cur.rs1;
  assign ifb.id_rs2_addr  = cur.rs2;
  assign ifb.id_rs1_used  = cur.u1;
  assign ifb.id_rs2_used  = cur.u2;
  assign ifb.ex_load_en   = cur.ld;
  assign ifb.ex_rd_addr   = cur.rd;
  assign ifb.ex_mc_start  = cur.mc;
  assign ifb.branch_taken = cur.br;

  hazard_stall_ctrl #(.LOAD_LAT(1), .MC_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(cur.rst), .bus(ifa)
  );
  hazard_stall_ctrl #(.LOAD_LAT(3), .MC_LAT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(cur.rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(logic rst, logic [31:0] inst, logic [31:0] pc,
                               logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic ld, logic [4:0] rd, logic mc, logic br);
    stim_t s;
    s = '{rst, inst, pc, rs1, rs2, u1, u2, ld, rd, mc, br};
    return s;
  endfunction

  function automatic exp_t ex(logic sf, logic sd, logic bd, logic be, logic ff, logic busy,
                              logic [31:0] inst, logic [31:0] pc, logic [15:0] cnt);
    exp_t e;
    e = '{sf, sd, bd, be, ff, busy, inst, pc, cnt};
    return e;
  endfunction

  function automatic stim_t idle_st();
    return st(1'b0, 32'h00000013, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t mdl_out(mstate_t s, stim_t i);
    exp_t e;
    logic hz;
    e      = '0;
    e.inst = i.inst;
    e.pc   = i.pc;
    if (i.rst) return e;
    e.cnt = 16'(s.cnt);
    hz = i.ld && (i.rd != 5'd0) &&
         ((i.u1 && (i.rs1 == i.rd)) || (i.u2 && (i.rs2 == i.rd)));
    if (s.rem == 0) begin
      if (i.br) begin
        e.ff = 1'b1; e.bd = 1'b1;
      end else if (i.mc) begin
        e.sf = 1'b1; e.sd = 1'b1; e.be = 1'b1;
      end else if (hz) begin
        e.sf = 1'b1; e.bd = 1'b1;
      end
    end else begin
      e.busy = 1'b1;
      e.inst = s.hi;
      e.pc   = s.hp;
      if (s.mc) begin
        e.sf = 1'b1; e.sd = 1'b1; e.be = 1'b1;
      end else if (i.br) begin
        e.ff = 1'b1; e.bd = 1'b1;
      end else begin
        e.sf = 1'b1; e.bd = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic mstate_t mdl_next(mstate_t s, stim_t i, int ll, int ml, int cmax);
    exp_t e;
    mstate_t n;
    e = mdl_out(s, i);
    n = s;
    if (i.rst) begin
      n.rem = 0; n.mc = 1'b0; n.hi = 32'h00000013; n.hp = 32'h0; n.cnt = 0;
      return n;
    end
    if (e.sf && (s.cnt < cmax)) n.cnt = s.cnt + 1;
    if (s.rem == 0) begin
      if (!i.br && (i.mc || e.sf)) begin
        n.hi  = i.inst;
        n.hp  = i.pc;
        n.mc  = i.mc;
        n.rem = (i.mc ? ml : ll) - 1;
      end
    end else if (!s.mc && i.br) begin
      n.rem = 0;
    end else begin
      n.rem = s.rem - 1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [85:0] act, input logic [85:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    obs_a = {ifa.stall_f, ifa.stall_d, ifa.bubble_d, ifa.bubble_e, ifa.flush_fd, ifa.busy,
             ifa.inst_out, ifa.pc_out, ifa.stall_count};
    obs_b = {ifb.stall_f, ifb.stall_d, ifb.bubble_d, ifb.bubble_e, ifb.flush_fd, ifb.busy,
             ifb.inst_out, ifb.pc_out, 12'h000, ifb.stall_count};
    chk("model_a", obs_a, mdl_out(m_a, cur));
    chk("model_b", obs_b, mdl_out(m_b, cur));
    @(posedge clk);
    m_a = mdl_next(m_a, cur, 1, 4, 65535);
    m_b = mdl_next(m_b, cur, 3, 4, 15);
    #1;
  endtask

  task automatic apply(input stim_t s);
    cur = s;
    step();
  endtask

  initial begin
    stim_t r;
    stim_t hz7;
    checks   = 0;
    failures = 0;
    m_a = '{rem: 0, mc: 1'b0, hi: 32'h00000013, hp: 32'h0, cnt: 0};
    m_b = m_a;
    cur = idle_st();
    cur.rst = 1'b1;

    // Directed table for the LOAD_LAT=1 / MC_LAT=4 configuration
    tbl[0]  = '{st(1'b1, 32'h11111111, 32'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111, 32'h000, 16'd0)};
    tbl[1]  = '{st(1'b0, 32'h00528293, 32'h100, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0),
                ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00528293, 32'h100, 16'd0)};
    tbl[2]  = '{st(1'b0, 32'h00528293, 32'h100, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00528293, 32'h100, 16'd1)};
    tbl[3]  = '{st(1'b0, 32'h00000033, 32'h104, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000033, 32'h104, 16'd1)};
    tbl[4]  = '{st(1'b0, 32'h00628313, 32'h108, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1),
                ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00628313, 32'h108, 16'd1)};
    tbl[5]  = '{st(1'b0, 32'hAAAA0001, 32'h200, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0),
                ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA0001, 32'h200, 16'd1)};
    tbl[6]  = '{st(1'b0, 32'hBBBB0002, 32'h204, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0),
                ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA0001, 32'h200, 16'd2)};
    tbl[7]  = '{st(1'b0, 32'hBBBB0002, 32'h204, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1),
                ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA0001, 32'h200, 16'd3)};
    tbl[8]  = '{st(1'b0, 32'hBBBB0002, 32'h204, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA0001, 32'h200, 16'd4)};
    tbl[9]  = '{st(1'b0, 32'hBBBB0002, 32'h204, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBBBB0002, 32'h204, 16'd5)};
    tbl[10] = '{st(1'b0, 32'hCCCC0003, 32'h208, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCCCC0003, 32'h208, 16'd5)};
    tbl[11] = '{st(1'b0, 32'hCCCC0003, 32'h208, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0),
                ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCCCC0003, 32'h208, 16'd5)};
    tbl[12] = '{st(1'b0, 32'hCCCC0003, 32'h208, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCCCC0003, 32'h208, 16'd6)};

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].s);
      chk($sformatf("vec%0d", i), obs_a, tbl[i].e);
    end

    // LOAD_LAT=3 on rs2: three stall cycles, busy on the last two
    r = idle_st(); r.rst = 1'b1; apply(r);
    hz7 = st(1'b0, 32'h00700393, 32'h300, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    apply(hz7);
    chk("ld3_c0", 86'({obs_b.sf, obs_b.busy}), 86'(2'b10));
    apply(idle_st());
    chk("ld3_c1", 86'({obs_b.sf, obs_b.busy, obs_b.inst}), 86'({2'b11, 32'h00700393}));
    apply(idle_st());
    chk("ld3_c2", 86'({obs_b.sf, obs_b.busy, obs_b.pc}), 86'({2'b11, 32'h300}));
    apply(st(1'b0, 32'h00000013, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0));
    chk("ld3_c3_x0", 86'({obs_b.sf, obs_b.busy}), 86'(2'b00));
    chk("ld3_count", 86'(obs_b.cnt), 86'(16'd3));

    // Branch in the second LD_STALL cycle aborts the stall
    apply(hz7);
    apply(idle_st());
    r = idle_st(); r.br = 1'b1; apply(r);
    chk("ld_abort", 86'({obs_b.sf, obs_b.bd, obs_b.ff, obs_b.busy}), 86'(4'b0111));
    apply(idle_st());
    chk("ld_abort_after", 86'({obs_b.sf, obs_b.busy}), 86'(2'b00));

    // Reset in the second MC_BUSY cycle
    r = idle_st(); r.mc = 1'b1; apply(r);
    chk("mc_c0", 86'({obs_b.sf, obs_b.sd, obs_b.be}), 86'(3'b111));
    apply(idle_st());
    r = idle_st(); r.rst = 1'b1; apply(r);
    apply(idle_st());
    chk("mc_reset", 86'({obs_b.sf, obs_b.sd, obs_b.bd, obs_b.be, obs_b.ff, obs_b.busy, obs_b.cnt}),
        86'({6'b000000, 16'd0}));

    // Twenty back-to-back stall cycles saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      r = idle_st(); r.mc = 1'b1; apply(r);
    end
    apply(idle_st());
    chk("sat15", 86'(obs_b.cnt), 86'(16'd15));

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r.rst  = ($urandom_range(0, 49) == 0);
      r.inst = $urandom;
      r.pc   = $urandom;
      r.rs1  = 5'($urandom_range(0, 3));
      r.rs2  = 5'($urandom_range(0, 3));
      r.u1   = 1'($urandom_range(0, 1));
      r.u2   = 1'($urandom_range(0, 1));
      r.ld   = 1'($urandom_range(0, 1));
      r.rd   = 5'($urandom_range(0, 3));
      r.mc   = ($urandom_range(0, 9) == 0);
      r.br   = ($urandom_range(0, 7) == 0);
      apply(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
